// File: rtl/rocc_cmd_issuer_if.sv
// Core-side RoCC bundle: request, command, response, writeback, fence and status.
// master is the issuer's view; slave is the view of the core/accelerator environment.
interface rocc_cmd_issuer_if #(
  parameter int INST_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic [INST_WIDTH-1:0] req_inst;
  logic [DATA_WIDTH-1:0] req_rs1;
  logic [DATA_WIDTH-1:0] req_rs2;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [INST_WIDTH-1:0] cmd_inst;
  logic [DATA_WIDTH-1:0] cmd_rs1;
  logic [DATA_WIDTH-1:0] cmd_rs2;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [4:0]            resp_rd;
  logic [DATA_WIDTH-1:0] resp_data;

  logic                  wb_en;
  logic [4:0]            wb_rd;
  logic [DATA_WIDTH-1:0] wb_data;

  logic                  fence_req;
  logic                  fence_done;
  logic                  busy;
  logic [4:0]            outstanding;
  logic                  err_unexpected;

  modport master (
    input  req_valid, req_inst, req_rs1, req_rs2,
    output req_ready,
    output cmd_valid, cmd_inst, cmd_rs1, cmd_rs2,
    input  cmd_ready,
    input  resp_valid, resp_rd, resp_data,
    output resp_ready,
    output wb_en, wb_rd, wb_data,
    input  fence_req,
    output fence_done, busy, outstanding, err_unexpected
  );

  modport slave (
    output req_valid, req_inst, req_rs1, req_rs2,
    input  req_ready,
    input  cmd_valid, cmd_inst, cmd_rs1, cmd_rs2,
    output cmd_ready,
    output resp_valid, resp_rd, resp_data,
    input  resp_ready,
    input  wb_en, wb_rd, wb_data,
    output fence_req,
    input  fence_done, busy, outstanding, err_unexpected
  );
endinterface

// File: rtl/rocc_cmd_issuer.sv
// RoCC command issuer: command FIFO, per-rd pending scoreboard for xd=1 commands,
// response-to-writeback conversion and a fence that drains all buffered and in-flight work.
module rocc_cmd_issuer #(
  parameter int INST_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  rocc_cmd_issuer_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic {ST_RUN, ST_FENCE} state_t;

  state_t state_q, state_d;

  logic [INST_WIDTH-1:0] inst_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs1_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] rs2_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      pending_q, pending_d;
  logic [4:0]       outstanding_q, outstanding_d;
  logic             alive_q;

  logic                  wb_en_q, err_q, fence_done_q;
  logic [4:0]            wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_data_q;

  logic                  empty, full, drained;
  logic [INST_WIDTH-1:0] head_inst;
  logic                  head_xd;
  logic [4:0]            head_rd;
  logic                  cmd_valid, req_ready, enq, deq, issue_xd;
  logic                  resp_fire, resp_hit;
  logic                  fence_done_d, busy;

  // Issue gate looks only at registered state, so a raised cmd_valid cannot be withdrawn.
  assign empty     = (count_q == '0);
  assign full      = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign drained   = empty && (outstanding_q == 5'd0);
  assign head_inst = inst_mem[rd_ptr_q];
  assign head_xd   = head_inst[14];
  assign head_rd   = head_inst[11:7];
  assign cmd_valid = !empty &&
                     !(head_xd && ((outstanding_q == 5'(MAX_OUTSTANDING)) || pending_q[head_rd]));

  assign enq       = bus.req_valid && req_ready;
  assign deq       = cmd_valid && bus.cmd_ready;
  assign issue_xd  = deq && head_xd;
  assign resp_fire = bus.resp_valid && alive_q;
  assign resp_hit  = resp_fire && pending_q[bus.resp_rd];

  always_comb begin
    count_d = count_q;
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A same-cycle issue and response touch different rd bits; issue to a pending rd is gated off.
  always_comb begin
    pending_d = pending_q;
    if (resp_hit) pending_d[bus.resp_rd] = 1'b0;
    if (issue_xd) pending_d[head_rd]     = 1'b1;
    outstanding_d = outstanding_q;
    case ({issue_xd, resp_hit})
      2'b10:   outstanding_d = outstanding_q + 5'd1;
      2'b01:   outstanding_d = outstanding_q - 5'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr_q] <= bus.req_inst;
      rs1_mem[wr_ptr_q]  <= bus.req_rs1;
      rs2_mem[wr_ptr_q]  <= bus.req_rs2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pending_q     <= '0;
      outstanding_q <= 5'd0;
      alive_q       <= 1'b0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q       <= count_d;
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
      alive_q       <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en_q   <= 1'b0;
      wb_rd_q   <= 5'd0;
      wb_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_en_q <= resp_hit;
      err_q   <= resp_fire && !resp_hit;
      if (resp_hit) begin
        wb_rd_q   <= bus.resp_rd;
        wb_data_q <= bus.resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      fence_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fence_done_q <= fence_done_d;
    end
  end

  // fence_req while already fencing is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.fence_req) state_d = ST_FENCE;
      ST_FENCE: if (drained)       state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    req_ready    = alive_q && !full && (state_q == ST_RUN);
    fence_done_d = (state_q == ST_FENCE) && drained;
    busy         = !empty || (outstanding_q != 5'd0) || (state_q == ST_FENCE);
  end

  assign bus.req_ready      = req_ready;
  assign bus.cmd_valid      = cmd_valid;
  assign bus.cmd_inst       = head_inst;
  assign bus.cmd_rs1        = rs1_mem[rd_ptr_q];
  assign bus.cmd_rs2        = rs2_mem[rd_ptr_q];
  assign bus.resp_ready     = alive_q;
  assign bus.wb_en          = wb_en_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.fence_done     = fence_done_q;
  assign bus.busy           = busy;
  assign bus.outstanding    = outstanding_q;
  assign bus.err_unexpected = err_q;

endmodule

// File: tb/tb_rocc_cmd_issuer.sv
// Scoreboard bench for rocc_cmd_issuer: stimulus queues expected commands/writebacks,
// a negedge monitor pops and compares whenever the DUT issues, writes back or flags an error.
module tb_rocc_cmd_issuer;

  localparam int IW = 32;
  localparam int DW = 64;

  typedef struct packed {
    logic [IW-1:0] inst;
    logic [DW-1:0] rs1;
    logic [DW-1:0] rs2;
  } cmd_t;

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_expected = 0;

  cmd_t cmd_q[$];
  wb_t  wb_q[$];

  logic [IW-1:0] first_inst;

  rocc_cmd_issuer_if #(.INST_WIDTH(IW), .DATA_WIDTH(DW)) bus ();

  rocc_cmd_issuer #(
    .INST_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_DEPTH(4), .MAX_OUTSTANDING(4)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] mk_inst(input logic xd, input logic [4:0] rd);
    return {7'h01, 5'd2, 5'd1, xd, 2'b11, rd, 7'h0b};
  endfunction

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [IW-1:0] inst, input logic [DW-1:0] rs1, input logic [DW-1:0] rs2);
    logic accepted;
    accepted      = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_inst  = inst;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        @(posedge clk);
        accepted = 1'b1;
        cmd_q.push_back('{inst: inst, rs1: rs1, rs2: rs2});
      end
    end
    #1;
    bus.req_valid = 1'b0;
    check_output("req_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic send_resp(input logic [4:0] rd, input logic [DW-1:0] data, input logic hit);
    bus.resp_valid = 1'b1;
    bus.resp_rd    = rd;
    bus.resp_data  = data;
    if (hit) wb_q.push_back('{rd: rd, data: data});
    else     err_expected++;
    step();
    bus.resp_valid = 1'b0;
  endtask

  // Monitor: one comparison set per observed issue, writeback or error pulse.
  initial begin
    cmd_t exp_cmd;
    wb_t  exp_wb;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          if (cmd_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL cmd_issue: got inst 0x%0h, expected no issue", bus.cmd_inst);
          end else begin
            exp_cmd = cmd_q.pop_front();
            check_output("cmd_inst", 64'(bus.cmd_inst), 64'(exp_cmd.inst));
            check_output("cmd_rs1", bus.cmd_rs1, exp_cmd.rs1);
            check_output("cmd_rs2", bus.cmd_rs2, exp_cmd.rs2);
          end
        end
        if (bus.wb_en) begin
          if (wb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL wb_en: got writeback rd %0d, expected none", bus.wb_rd);
          end else begin
            exp_wb = wb_q.pop_front();
            check_output("wb_rd", 64'(bus.wb_rd), 64'(exp_wb.rd));
            check_output("wb_data", bus.wb_data, exp_wb.data);
          end
        end
        if (bus.err_unexpected) begin
          tests_run++;
          if (err_expected == 0) begin
            tests_failed++;
            $display("[TB] FAIL err_unexpected: got 1, expected 0");
          end else begin
            err_expected--;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_inst   = '0;
    bus.req_rs1    = '0;
    bus.req_rs2    = '0;
    bus.cmd_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_rd    = 5'd0;
    bus.resp_data  = '0;
    bus.fence_req  = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check_output("rst_resp_ready", 64'(bus.resp_ready), 64'd0);
    check_output("rst_busy", 64'(bus.busy), 64'd0);
    check_output("rst_wb_en", 64'(bus.wb_en), 64'd0);
    check_output("rst_wb_data", bus.wb_data, 64'd0);
    check_output("rst_outstanding", 64'(bus.outstanding), 64'd0);
    rst_n = 1'b1;
    step();
    check_output("post_rst_req_ready", 64'(bus.req_ready), 64'd1);
    check_output("post_rst_resp_ready", 64'(bus.resp_ready), 64'd1);

    // Single xd=1 round trip
    bus.cmd_ready = 1'b1;
    apply_stimulus(32'h0200_40ab, 64'h1, 64'h2);
    check_output("t1_cmd_valid", 64'(bus.cmd_valid), 64'd1);
    step();
    check_output("t1_outstanding", 64'(bus.outstanding), 64'd1);
    send_resp(5'd1, 64'hdead, 1'b1);
    check_output("t1_wb_en", 64'(bus.wb_en), 64'd1);
    check_output("t1_outstanding_after", 64'(bus.outstanding), 64'd0);
    step();
    check_output("t1_wb_pulse_end", 64'(bus.wb_en), 64'd0);

    // FIFO fill under backpressure, then drain on consecutive cycles
    bus.cmd_ready = 1'b0;
    first_inst = mk_inst(1'b0, 5'd10);
    for (int i = 0; i < 4; i++)
      apply_stimulus(mk_inst(1'b0, 5'(10 + i)), 64'(16'h100 + i), 64'(16'h200 + i));
    check_output("t2_full_req_ready", 64'(bus.req_ready), 64'd0);
    check_output("t2_head_inst", 64'(bus.cmd_inst), 64'(first_inst));
    step();
    step();
    check_output("t2_head_stable", 64'(bus.cmd_inst), 64'(first_inst));
    bus.cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_output("t2_drain_valid", 64'(bus.cmd_valid), 64'd1);
      step();
    end
    check_output("t2_drained", 64'(bus.cmd_valid), 64'd0);

    // MAX_OUTSTANDING limit
    for (int i = 1; i <= 5; i++)
      apply_stimulus(mk_inst(1'b1, 5'(i)), 64'(16'h300 + i), 64'd0);
    repeat (3) step();
    check_output("t3_outstanding_max", 64'(bus.outstanding), 64'd4);
    check_output("t3_stalled", 64'(bus.cmd_valid), 64'd0);
    send_resp(5'd2, 64'h22, 1'b1);
    check_output("t3_released", 64'(bus.cmd_valid), 64'd1);
    step();
    check_output("t3_outstanding_refill", 64'(bus.outstanding), 64'd4);
    send_resp(5'd1, 64'h11, 1'b1);
    send_resp(5'd3, 64'h33, 1'b1);
    send_resp(5'd4, 64'h44, 1'b1);
    send_resp(5'd5, 64'h55, 1'b1);
    check_output("t3_outstanding_zero", 64'(bus.outstanding), 64'd0);

    // Same-rd hazard
    apply_stimulus(mk_inst(1'b1, 5'd7), 64'hA7, 64'd0);
    apply_stimulus(mk_inst(1'b1, 5'd7), 64'hB7, 64'd0);
    repeat (3) step();
    check_output("t4_hazard_stall", 64'(bus.cmd_valid), 64'd0);
    check_output("t4_outstanding", 64'(bus.outstanding), 64'd1);
    send_resp(5'd7, 64'h77, 1'b1);
    check_output("t4_hazard_release", 64'(bus.cmd_valid), 64'd1);
    step();
    check_output("t4_outstanding_second", 64'(bus.outstanding), 64'd1);
    send_resp(5'd7, 64'h78, 1'b1);

    // Unexpected response
    send_resp(5'd9, 64'h99, 1'b0);
    check_output("t5_err", 64'(bus.err_unexpected), 64'd1);
    check_output("t5_no_wb", 64'(bus.wb_en), 64'd0);
    check_output("t5_outstanding", 64'(bus.outstanding), 64'd0);
    step();
    check_output("t5_err_pulse_end", 64'(bus.err_unexpected), 64'd0);

    // Fence with queued and outstanding work
    apply_stimulus(mk_inst(1'b1, 5'd3), 64'hC3, 64'd0);
    step();
    bus.cmd_ready = 1'b0;
    check_output("t6_outstanding", 64'(bus.outstanding), 64'd1);
    apply_stimulus(mk_inst(1'b0, 5'd20), 64'hD0, 64'd0);
    apply_stimulus(mk_inst(1'b0, 5'd21), 64'hE0, 64'd0);
    bus.fence_req = 1'b1;
    step();
    bus.fence_req = 1'b0;
    check_output("t6_fence_req_ready", 64'(bus.req_ready), 64'd0);
    check_output("t6_fence_busy", 64'(bus.busy), 64'd1);
    bus.cmd_ready = 1'b1;
    step();
    step();
    check_output("t6_fifo_empty_wait", 64'(bus.fence_done), 64'd0);
    check_output("t6_still_busy", 64'(bus.busy), 64'd1);
    send_resp(5'd3, 64'h333, 1'b1);
    check_output("t6_done_not_yet", 64'(bus.fence_done), 64'd0);
    check_output("t6_req_ready_fencing", 64'(bus.req_ready), 64'd0);
    step();
    check_output("t6_fence_done", 64'(bus.fence_done), 64'd1);
    check_output("t6_req_ready_back", 64'(bus.req_ready), 64'd1);
    step();
    check_output("t6_fence_done_pulse", 64'(bus.fence_done), 64'd0);

    // Idle fence completes two cycles after the request
    bus.fence_req = 1'b1;
    step();
    bus.fence_req = 1'b0;
    check_output("idle_fence_cycle1", 64'(bus.fence_done), 64'd0);
    check_output("idle_fence_busy", 64'(bus.busy), 64'd1);
    step();
    check_output("idle_fence_cycle2", 64'(bus.fence_done), 64'd1);
    step();
    check_output("idle_fence_end", 64'(bus.fence_done), 64'd0);

    // Reset mid-operation drops in-flight state; late responses become errors
    apply_stimulus(mk_inst(1'b1, 5'd4), 64'h44, 64'd0);
    step();
    check_output("mid_rst_outstanding_before", 64'(bus.outstanding), 64'd1);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_outstanding", 64'(bus.outstanding), 64'd0);
    check_output("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_output("mid_rst_resp_ready", 64'(bus.resp_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    send_resp(5'd4, 64'h4444, 1'b0);
    check_output("mid_rst_late_err", 64'(bus.err_unexpected), 64'd1);
    check_output("mid_rst_late_no_wb", 64'(bus.wb_en), 64'd0);

    repeat (3) step();
    check_output("end_cmd_q_empty", 64'(cmd_q.size()), 64'd0);
    check_output("end_wb_q_empty", 64'(wb_q.size()), 64'd0);
    check_output("end_err_expected", 64'(err_expected), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
